// File: rtl/systolic_seq_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
// The optional SYS_SEQ_PERF_EN build adds a perf counter width used by the top.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    localparam int unsigned PERF_W = 32;

    // Skewed compute window length for a DIM x DIM array.
    function automatic int unsigned compute_cycles(input int unsigned dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_hs_counter.sv
// Handshake counter: counts accepted transfers up to LIMIT and flags completion.
// done_nxt_o reports completion including the transfer accepted this cycle.
module seq_hs_counter
    import systolic_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o,
    output logic             done_nxt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done_o = (cnt_q == CNT_W'(LIMIT));

    // Never count past LIMIT, so there is no wrap-around.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign done_nxt_o = (cnt_d == CNT_W'(LIMIT));

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for one systolic matmul tile: clear, load A/B rows, compute, drain C rows.
// Define SYS_SEQ_PERF_EN to add the perf_cycles/perf_stall counters.
module systolic_seq_ctrl
    import systolic_seq_pkg::*;
#(
    parameter int unsigned DIM            = 8,
    parameter int unsigned COMPUTE_CYCLES = compute_cycles(DIM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    input  logic                          a_row_valid,
    output logic                          a_row_ready,
    input  logic                          b_row_valid,
    output logic                          b_row_ready,
    output logic                          memA_wr_en,
    output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] memA_row,
    output logic                          memB_wr_en,
    output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] memB_row,
    output logic                          mem_en,
    output logic                          sys_en,
    output logic                          sys_clr,
    output logic                          c_row_valid,
    input  logic                          c_row_ready,
    output logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] c_row_sel
`ifdef SYS_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]             perf_cycles,
    output logic [PERF_W-1:0]             perf_stall
`endif
);

    localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned CNT_W = $clog2(DIM + 1);
    localparam int unsigned CMP_W = $clog2(COMPUTE_CYCLES + 1);

    seq_state_t state_q;
    seq_state_t state_d;

    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] b_cnt;
    logic [CNT_W-1:0] c_cnt;
    logic             a_done;
    logic             b_done;
    logic             c_done;
    logic             a_done_nxt;
    logic             b_done_nxt;
    logic             c_done_nxt;
    logic             cnt_clear;
    logic             c_inc;
    logic [CMP_W-1:0] comp_q;
    logic [CMP_W-1:0] comp_d;
    logic             comp_last;

    assign cnt_clear  = (state_q == ST_CLEAR);
    assign memA_wr_en = a_row_valid & a_row_ready;
    assign memB_wr_en = b_row_valid & b_row_ready;
    assign c_inc      = c_row_valid & c_row_ready;
    assign comp_last  = (comp_q == CMP_W'(COMPUTE_CYCLES - 1));

    seq_hs_counter #(.LIMIT(DIM), .CNT_W(CNT_W)) u_a_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .inc_i      (memA_wr_en),
        .cnt_o      (a_cnt),
        .done_o     (a_done),
        .done_nxt_o (a_done_nxt)
    );

    seq_hs_counter #(.LIMIT(DIM), .CNT_W(CNT_W)) u_b_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .inc_i      (memB_wr_en),
        .cnt_o      (b_cnt),
        .done_o     (b_done),
        .done_nxt_o (b_done_nxt)
    );

    seq_hs_counter #(.LIMIT(DIM), .CNT_W(CNT_W)) u_c_cnt (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .inc_i      (c_inc),
        .cnt_o      (c_cnt),
        .done_o     (c_done),
        .done_nxt_o (c_done_nxt)
    );

    // Next-state logic; LOAD exits as soon as the last A/B handshake lands.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_CLEAR;
            ST_CLEAR:   state_d = ST_LOAD;
            ST_LOAD:    if (a_done_nxt && b_done_nxt) state_d = ST_COMPUTE;
            ST_COMPUTE: if (comp_last) state_d = ST_DRAIN;
            ST_DRAIN:   if (c_done_nxt && !c_done) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Moore output decode from state and counters.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        sys_clr     = 1'b0;
        a_row_ready = 1'b0;
        b_row_ready = 1'b0;
        memA_row    = '0;
        memB_row    = '0;
        mem_en      = 1'b0;
        sys_en      = 1'b0;
        c_row_valid = 1'b0;
        c_row_sel   = '0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                sys_clr = 1'b1;
            end
            ST_LOAD: begin
                busy        = 1'b1;
                a_row_ready = !a_done;
                b_row_ready = !b_done;
                memA_row    = ROW_W'(a_cnt);
                memB_row    = ROW_W'(b_cnt);
            end
            ST_COMPUTE: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                sys_en = 1'b1;
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                c_row_valid = !c_done;
                c_row_sel   = ROW_W'(c_cnt);
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_comb begin
        comp_d = '0;
        if (state_q == ST_COMPUTE && !comp_last) begin
            comp_d = comp_q + CMP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            comp_q  <= '0;
        end else begin
            state_q <= state_d;
            comp_q  <= comp_d;
        end
    end

`ifdef SYS_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_cycles_q;
    logic [PERF_W-1:0] perf_cycles_d;
    logic [PERF_W-1:0] perf_stall_q;
    logic [PERF_W-1:0] perf_stall_d;
    logic              start_acc;
    logic              stall_c;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign stall_c   = ((state_q == ST_LOAD) &&
                        ((!a_done && !a_row_valid) || (!b_done && !b_row_valid))) ||
                       ((state_q == ST_DRAIN) && !c_row_ready);

    // The start-accept cycle counts as the first cycle of the tile.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (start_acc) begin
            perf_cycles_d = PERF_W'(1);
            perf_stall_d  = '0;
        end else begin
            if (busy && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + PERF_W'(1);
            if (stall_c && perf_stall_q != '1) perf_stall_d = perf_stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`else
    // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl using a timeline reference model of one tile.
// Define SYS_SEQ_PERF_EN to also check the perf counters.
module tb_systolic_seq_ctrl;

    localparam int DIM  = 8;
    localparam int CC   = 3 * DIM - 2;
    localparam int MAXC = 400;

    logic       clk = 1'b0;
    logic       rst, start, a_row_valid, b_row_valid, c_row_ready;
    logic       busy, done, a_row_ready, b_row_ready, memA_wr_en, memB_wr_en;
    logic       mem_en, sys_en, sys_clr, c_row_valid;
    logic [2:0] memA_row, memB_row, c_row_sel;
`ifdef SYS_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    systolic_seq_ctrl #(.DIM(DIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .a_row_valid (a_row_valid),
        .a_row_ready (a_row_ready),
        .b_row_valid (b_row_valid),
        .b_row_ready (b_row_ready),
        .memA_wr_en  (memA_wr_en),
        .memA_row    (memA_row),
        .memB_wr_en  (memB_wr_en),
        .memB_row    (memB_row),
        .mem_en      (mem_en),
        .sys_en      (sys_en),
        .sys_clr     (sys_clr),
        .c_row_valid (c_row_valid),
        .c_row_ready (c_row_ready),
        .c_row_sel   (c_row_sel)
`ifdef SYS_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit av [MAXC];
    bit bv [MAXC];
    bit cr [MAXC];
    int obs_first_cv;
    int obs_done;

    // Random valid/ready patterns; everything forced high late so every tile finishes.
    task automatic gen(input int pa, input int pb, input int pc);
        for (int t = 0; t < MAXC; t++) begin
            av[t] = ($urandom_range(99) < pa) || (t >= 120);
            bv[t] = ($urandom_range(99) < pb) || (t >= 120);
            cr[t] = ($urandom_range(99) < pc) || (t >= 200);
        end
    endtask

    // One tile from its start-accept cycle (t=0). abort_at>=0 applies rst in that cycle.
    // chain holds start through DONE so the next call begins in the following IDLE cycle.
    task automatic run_tile(input int start_pulse_at, input int abort_at, input bit chain);
        int a_hs [DIM];
        int b_hs [DIM];
        int c_hs [DIM];
        int n, load_end, drain_start, done_c, last, exp_stall;
        int na, nb, nc;
        logic [9:0] e_v, o_v;
        n = 0;
        for (int t = 2; t < MAXC && n < DIM; t++) if (av[t]) begin a_hs[n] = t; n++; end
        n = 0;
        for (int t = 2; t < MAXC && n < DIM; t++) if (bv[t]) begin b_hs[n] = t; n++; end
        load_end    = (a_hs[DIM-1] > b_hs[DIM-1]) ? a_hs[DIM-1] : b_hs[DIM-1];
        drain_start = load_end + 1 + CC;
        n = 0;
        for (int t = drain_start; t < MAXC && n < DIM; t++) if (cr[t]) begin c_hs[n] = t; n++; end
        done_c = c_hs[DIM-1] + 1;
        exp_stall = 0;
        for (int t = 2; t <= load_end; t++)
            if ((t <= a_hs[DIM-1] && !av[t]) || (t <= b_hs[DIM-1] && !bv[t])) exp_stall++;
        for (int t = drain_start; t <= c_hs[DIM-1]; t++) if (!cr[t]) exp_stall++;
        last = (abort_at >= 0) ? abort_at : (chain ? done_c : done_c + 1);
        obs_first_cv = -1;
        obs_done     = -1;
        for (int t = 0; t <= last; t++) begin
            rst         = (t == abort_at);
            start       = (t == 0) || (t == start_pulse_at) || (chain && t == done_c);
            a_row_valid = av[t];
            b_row_valid = bv[t];
            c_row_ready = cr[t];
            na = 0; nb = 0; nc = 0;
            for (int k = 0; k < DIM; k++) begin
                if (a_hs[k] < t) na++;
                if (b_hs[k] < t) nb++;
                if (c_hs[k] < t) nc++;
            end
            e_v = {t >= 1 && t <= done_c, t == 1,
                   t >= 2 && t <= a_hs[DIM-1], t >= 2 && t <= a_hs[DIM-1] && av[t],
                   t >= 2 && t <= b_hs[DIM-1], t >= 2 && t <= b_hs[DIM-1] && bv[t],
                   t > load_end && t <= load_end + CC, t > load_end && t <= load_end + CC,
                   t >= drain_start && t <= c_hs[DIM-1], t == done_c};
            @(negedge clk);
            o_v = {busy, sys_clr, a_row_ready, memA_wr_en, b_row_ready, memB_wr_en,
                   mem_en, sys_en, c_row_valid, done};
            if (c_row_valid && obs_first_cv < 0) obs_first_cv = t;
            if (done) obs_done = t;
            checks++;
            if (o_v !== e_v) begin
                errors++;
                $display("FAIL ctrl t=%0d got %b want %b (busy clr ardy awr brdy bwr men sen cv done)",
                         t, o_v, e_v);
            end
            if (e_v[6]) begin
                checks++;
                if (memA_row !== 3'(na)) begin
                    errors++;
                    $display("FAIL memA_row t=%0d got %0d want %0d", t, memA_row, na);
                end
            end
            if (e_v[4]) begin
                checks++;
                if (memB_row !== 3'(nb)) begin
                    errors++;
                    $display("FAIL memB_row t=%0d got %0d want %0d", t, memB_row, nb);
                end
            end
            if (e_v[1]) begin
                checks++;
                if (c_row_sel !== 3'(nc)) begin
                    errors++;
                    $display("FAIL c_row_sel t=%0d got %0d want %0d", t, c_row_sel, nc);
                end
            end
`ifdef SYS_SEQ_PERF_EN
            if (abort_at < 0 && !chain && t == last) begin
                checks++;
                if (perf_cycles !== 32'(done_c + 1) || perf_stall !== 32'(exp_stall)) begin
                    errors++;
                    $display("FAIL perf got cycles=%0d stall=%0d want cycles=%0d stall=%0d",
                             perf_cycles, perf_stall, done_c + 1, exp_stall);
                end
            end
`endif
            @(posedge clk);
            #1;
        end
        if (abort_at >= 0) begin
            rst   = 1'b0;
            start = 1'b0;
            @(negedge clk);
            o_v = {busy, sys_clr, a_row_ready, memA_wr_en, b_row_ready, memB_wr_en,
                   mem_en, sys_en, c_row_valid, done};
            checks++;
            if (o_v !== 10'b0 || {memA_row, memB_row, c_row_sel} !== 9'b0) begin
                errors++;
                $display("FAIL abort outputs got %b rows %b want all zero", o_v,
                         {memA_row, memB_row, c_row_sel});
            end
`ifdef SYS_SEQ_PERF_EN
            checks++;
            if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
                errors++;
                $display("FAIL abort perf got %0d/%0d want 0/0", perf_cycles, perf_stall);
            end
`endif
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] o_v;
        rst = 1'b1; start = 1'b1; a_row_valid = 1'b1; b_row_valid = 1'b1; c_row_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        o_v = {busy, sys_clr, a_row_ready, memA_wr_en, b_row_ready, memB_wr_en,
               mem_en, sys_en, c_row_valid, done};
        checks++;
        if (o_v !== 10'b0 || {memA_row, memB_row, c_row_sel} !== 9'b0) begin
            errors++;
            $display("FAIL reset outputs got %b rows %b want all zero", o_v,
                     {memA_row, memB_row, c_row_sel});
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_baseline();
        gen(100, 100, 100);
        run_tile(-1, -1, 1'b0);
        checks++;
        if (obs_first_cv !== 32 || obs_done !== 40) begin
            errors++;
            $display("FAIL baseline latency got cv=%0d done=%0d want cv=32 done=40",
                     obs_first_cv, obs_done);
        end
    endtask

    task automatic test_b_delayed();
        gen(100, 100, 100);
        for (int t = 0; t < 6; t++) bv[t] = 1'b0;
        run_tile(-1, -1, 1'b0);
        checks++;
        if (obs_first_cv !== 36) begin
            errors++;
            $display("FAIL b_delayed first c_row_valid got %0d want 36", obs_first_cv);
        end
    endtask

    task automatic test_drain_backpressure();
        gen(100, 100, 100);
        for (int t = 34; t < 37; t++) cr[t] = 1'b0;
        run_tile(-1, -1, 1'b0);
        checks++;
        if (obs_done !== 43) begin
            errors++;
            $display("FAIL backpressure done cycle got %0d want 43", obs_done);
        end
    endtask

    task automatic test_start_while_busy();
        gen(100, 100, 100);
        run_tile(15, -1, 1'b1);
        gen(100, 100, 100);
        run_tile(-1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        gen(100, 100, 100);
        run_tile(-1, 15, 1'b0);
        gen(100, 100, 100);
        run_tile(-1, -1, 1'b0);
        checks++;
        if (obs_done !== 40) begin
            errors++;
            $display("FAIL post-reset done cycle got %0d want 40", obs_done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            gen(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)));
            run_tile((i % 3 == 0) ? int'($urandom_range(3, 30)) : -1, -1, 1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_b_delayed();
        test_drain_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
